// File: rtl/id_ex_operand_reg.sv
// -----------------------------------------------------------------------------
// id_ex_operand_reg
//
// ID/EX pipeline register for the 5-stage core. Captures the decoded ID fields
// and the rs1/rs2 operands into the EX slot. Three things happen here on top of
// a plain pipeline register:
//   * Same-cycle writeback bypass. The register file writes on the clock edge,
//     so a read in the same cycle returns the old value. The WB write port is
//     snooped and substituted into the captured operand.
//   * Load-use hazard detection. A load in EX whose rd feeds the ID
//     instruction stalls ID for one cycle and injects one bubble into EX.
//   * Branch-redirect flush. i_flush kills the ID instruction by loading a
//     bubble.
//
// Handshake semantics: this stage has no valid/ready pair. The EX stage
// advances every cycle unless i_ex_stall is high, in which case it holds.
// o_id_stall tells upstream (PC, IF/ID) to hold its contents. A slot with
// o_ex_valid = 0 is a bubble: o_ex_rd_wren and o_ex_is_load are then 0, so
// it never writes, never raises a hazard and never forwards.
//
// Ports:
//   i_clk, i_rst              clock; synchronous active-high reset
//   i_id_*                    decoded ID instruction (valid, pc, rs/rd
//                             addresses, use flags, load flag, imm, ctrl)
//   i_rf_rs1/rs2_data         combinational register-file read data
//   i_wb_rd_wren/addr/data    writeback port (same as register-file write)
//   i_ex_stall                hold EX contents (operands still refresh)
//   i_flush                   kill the ID instruction
//   o_ex_*                    registered EX-slot contents
//   o_id_stall                combinational stall towards PC and IF/ID
// -----------------------------------------------------------------------------
module id_ex_operand_reg #(
  parameter int CTRL_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [31:0]       i_id_pc,
  input  logic [4:0]        i_id_rs1_addr,
  input  logic [4:0]        i_id_rs2_addr,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [4:0]        i_id_rd_addr,
  input  logic              i_id_rd_wren,
  input  logic              i_id_is_load,
  input  logic [31:0]       i_id_imm,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic [31:0]       i_rf_rs1_data,
  input  logic [31:0]       i_rf_rs2_data,
  input  logic              i_wb_rd_wren,
  input  logic [4:0]        i_wb_rd_addr,
  input  logic [31:0]       i_wb_rd_data,
  input  logic              i_ex_stall,
  input  logic              i_flush,
  output logic              o_ex_valid,
  output logic [31:0]       o_ex_pc,
  output logic [31:0]       o_ex_imm,
  output logic [4:0]        o_ex_rs1_addr,
  output logic [4:0]        o_ex_rs2_addr,
  output logic [4:0]        o_ex_rd_addr,
  output logic [31:0]       o_ex_rs1_data,
  output logic [31:0]       o_ex_rs2_data,
  output logic              o_ex_rd_wren,
  output logic              o_ex_is_load,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic              o_id_stall
);

  // A writeback to x0 is discarded by the register file, so it must never be
  // bypassed either.
  logic        wb_live;
  logic [31:0] rs1_res;
  logic [31:0] rs2_res;
  logic        hz;
  logic        hz_rs1;
  logic        hz_rs2;
  logic        wb_hits_ex_rs1;
  logic        wb_hits_ex_rs2;

  assign wb_live = i_wb_rd_wren && (i_wb_rd_addr != 5'd0);

  // Operand resolution for the instruction currently in ID.
  always_comb begin
    rs1_res = i_rf_rs1_data;
    rs2_res = i_rf_rs2_data;
    if (i_id_rs1_addr == 5'd0) begin
      rs1_res = 32'd0;
    end else if (wb_live && (i_wb_rd_addr == i_id_rs1_addr)) begin
      rs1_res = i_wb_rd_data;
    end
    if (i_id_rs2_addr == 5'd0) begin
      rs2_res = 32'd0;
    end else if (wb_live && (i_wb_rd_addr == i_id_rs2_addr)) begin
      rs2_res = i_wb_rd_data;
    end
  end

  // Load-use hazard: the load result is only available after MEM, so the
  // consumer has to wait one cycle. A bubble has is_load = 0 and never matches.
  assign hz_rs1 = i_id_rs1_used && (i_id_rs1_addr == o_ex_rd_addr);
  assign hz_rs2 = i_id_rs2_used && (i_id_rs2_addr == o_ex_rd_addr);
  assign hz     = o_ex_valid && o_ex_is_load && (o_ex_rd_addr != 5'd0) &&
                  i_id_valid && (hz_rs1 || hz_rs2);

  assign o_id_stall = !i_rst && !i_flush && (i_ex_stall || hz);

  // While EX is held, the instruction in it still needs any value that is
  // written back meanwhile; otherwise the write would be lost to it.
  assign wb_hits_ex_rs1 = wb_live && (i_wb_rd_addr == o_ex_rs1_addr);
  assign wb_hits_ex_rs2 = wb_live && (i_wb_rd_addr == o_ex_rs2_addr);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      // Reset and flush both load an all-zero bubble.
      o_ex_valid    <= 1'b0;
      o_ex_pc       <= 32'd0;
      o_ex_imm      <= 32'd0;
      o_ex_rs1_addr <= 5'd0;
      o_ex_rs2_addr <= 5'd0;
      o_ex_rd_addr  <= 5'd0;
      o_ex_rs1_data <= 32'd0;
      o_ex_rs2_data <= 32'd0;
      o_ex_rd_wren  <= 1'b0;
      o_ex_is_load  <= 1'b0;
      o_ex_ctrl     <= '0;
    end else if (i_ex_stall) begin
      if (wb_hits_ex_rs1) begin
        o_ex_rs1_data <= i_wb_rd_data;
      end
      if (wb_hits_ex_rs2) begin
        o_ex_rs2_data <= i_wb_rd_data;
      end
    end else if (hz) begin
      o_ex_valid    <= 1'b0;
      o_ex_pc       <= 32'd0;
      o_ex_imm      <= 32'd0;
      o_ex_rs1_addr <= 5'd0;
      o_ex_rs2_addr <= 5'd0;
      o_ex_rd_addr  <= 5'd0;
      o_ex_rs1_data <= 32'd0;
      o_ex_rs2_data <= 32'd0;
      o_ex_rd_wren  <= 1'b0;
      o_ex_is_load  <= 1'b0;
      o_ex_ctrl     <= '0;
    end else begin
      o_ex_valid    <= i_id_valid;
      o_ex_pc       <= i_id_pc;
      o_ex_imm      <= i_id_imm;
      o_ex_rs1_addr <= i_id_rs1_addr;
      o_ex_rs2_addr <= i_id_rs2_addr;
      o_ex_rd_addr  <= i_id_rd_addr;
      o_ex_rs1_data <= rs1_res;
      o_ex_rs2_data <= rs2_res;
      o_ex_rd_wren  <= i_id_valid && i_id_rd_wren;
      o_ex_is_load  <= i_id_valid && i_id_is_load;
      o_ex_ctrl     <= i_id_ctrl;
    end
  end

endmodule
